mem_access_unit: RTL and testbench

Memory-stage load/store unit of the five-stage pipeline. It takes the access issued by the EX/MEM register and runs a valid/ready transaction on the data bus. It aligns and sign-extends load data into `rdata`, which the MEM/WB register captures. While a transaction is in flight it stalls the pipeline, and it flags misaligned accesses and bus timeouts.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/load_align.sv | 34 +++
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package mem_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Command held on the bus for the whole transaction.
    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } bus_cmd_t;

    // Wait counter must hold values up to TIMEOUT.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Valid/ready data-bus bundle between the load/store unit and memory.
interface mem_access_unit_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_rdata, bus_ready
    );

endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a bus word and extends it per funct3.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        case (off_i)
            2'd0:    byte_c = rdata_i[7:0];
            2'd1:    byte_c = rdata_i[15:8];
            2'd2:    byte_c = rdata_i[23:16];
            default: byte_c = rdata_i[31:24];
        endcase
        half_c = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        // Reserved funct3 codes fall through to the full word.
        case (funct3_i)
            F3_LB:   result_o = {{24{byte_c[7]}}, byte_c};
            F3_LBU:  result_o = {24'b0, byte_c};
            F3_LH:   result_o = {{16{half_c[15]}}, half_c};
            F3_LHU:  result_o = {16'b0, half_c};
            F3_LW:   result_o = rdata_i;
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: launches aligned accesses on the valid/ready bus,
// stalls the pipeline while in flight, formats load data, flags faults.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_enM,
    input  logic               wr_enM,
    input  logic [2:0]         funct3M,
    input  logic [31:0]        ALUResultM,
    input  logic [31:0]        wdataM,
    mem_access_unit_if.master  bus,
    output logic [31:0]        rdata,
    output logic               stall_mem,
    output logic               misaligned,
    output logic               bus_err
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    state_e           state_q, state_d;
    bus_cmd_t         cmd_q, cmd_d;
    logic             bus_req_q, bus_req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             bus_err_q, bus_err_d;
    logic             ld_q, ld_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;

    logic        access_c, sz_byte_c, sz_half_c, misalign_c, launch_c, last_c;
    logic [3:0]  strb_c;
    logic [31:0] wdata_c;
    logic [31:0] aligned_c;

    assign access_c   = rd_enM | wr_enM;
    assign sz_byte_c  = (funct3M[1:0] == F3_SB[1:0]);
    assign sz_half_c  = (funct3M[1:0] == F3_SH[1:0]);
    assign misalign_c = access_c && (state_q == ST_IDLE) &&
                        ((sz_half_c && ALUResultM[0]) ||
                         (!sz_byte_c && !sz_half_c && (ALUResultM[1:0] != 2'b00)));
    assign launch_c   = access_c && (state_q == ST_IDLE) && !misalign_c;
    assign last_c     = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Store lane placement: strobes shifted to the addressed lane, data replicated.
    always_comb begin
        strb_c  = 4'b1111;
        wdata_c = wdataM;
        if (sz_byte_c) begin
            strb_c  = 4'b0001 << ALUResultM[1:0];
            wdata_c = {4{wdataM[7:0]}};
        end else if (sz_half_c) begin
            strb_c  = 4'b0011 << {ALUResultM[1], 1'b0};
            wdata_c = {2{wdataM[15:0]}};
        end
    end

    load_align u_load_align (
        .rdata_i  (bus.bus_rdata),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .result_o (aligned_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch_c) state_d = ST_BUSY;
            ST_BUSY: if (bus.bus_ready || last_c) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_d     = cmd_q;
        bus_req_d = 1'b0;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        bus_err_d = 1'b0;
        ld_d      = ld_q;
        f3_d      = f3_q;
        off_d     = off_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (launch_c) begin
                    // Load wins when both enables are high.
                    cmd_d.we    = wr_enM & ~rd_enM;
                    cmd_d.addr  = {ALUResultM[31:2], 2'b00};
                    cmd_d.wdata = wdata_c;
                    cmd_d.wstrb = rd_enM ? 4'b0000 : strb_c;
                    bus_req_d   = 1'b1;
                    ld_d        = rd_enM;
                    f3_d        = funct3M;
                    off_d       = ALUResultM[1:0];
                end
            end
            ST_BUSY: begin
                if (bus.bus_ready) begin
                    if (ld_q) rdata_d = aligned_c;
                end else if (last_c) begin
                    // Timed-out loads return zero; stores keep the last load result.
                    bus_err_d = 1'b1;
                    if (ld_q) rdata_d = '0;
                end else begin
                    bus_req_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q     <= '0;
            bus_req_q <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            ld_q      <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
        end else begin
            cmd_q     <= cmd_d;
            bus_req_q <= bus_req_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            ld_q      <= ld_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = cmd_q.we;
    assign bus.bus_addr  = cmd_q.addr;
    assign bus.bus_wdata = cmd_q.wdata;
    assign bus.bus_wstrb = cmd_q.wstrb;

    assign rdata      = rdata_q;
    assign bus_err    = bus_err_q;
    assign misaligned = misalign_c;
    assign stall_mem  = launch_c | (state_q == ST_BUSY);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT = 4) with hand-computed expectations.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        rd_enM;
    logic        wr_enM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] wdataM;
    logic [31:0] rdata;
    logic        stall_mem;
    logic        misaligned;
    logic        bus_err;

    int n_cmp;
    int n_err;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_enM     (rd_enM),
        .wr_enM     (wr_enM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .wdataM     (wdataM),
        .bus        (bus_if),
        .rdata      (rdata),
        .stall_mem  (stall_mem),
        .misaligned (misaligned),
        .bus_err    (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        rd_enM           = 1'b0;
        wr_enM           = 1'b0;
        bus_if.bus_ready = 1'b0;
    endtask

    // Load answered on the first BUSY cycle; ends back in IDLE.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp);
        rd_enM = 1'b1; wr_enM = 1'b0; funct3M = f3; ALUResultM = addr;
        bus_if.bus_rdata = data; bus_if.bus_ready = 1'b1;
        #1;
        chk({tag, " launch stall"}, 32'(stall_mem), 32'd1);
        chk({tag, " launch misaligned"}, 32'(misaligned), 32'd0);
        step();
        chk({tag, " busy req"}, 32'(bus_if.bus_req), 32'd1);
        chk({tag, " busy stall"}, 32'(stall_mem), 32'd1);
        chk({tag, " addr"}, bus_if.bus_addr, {addr[31:2], 2'b00});
        chk({tag, " we"}, 32'(bus_if.bus_we), 32'd0);
        chk({tag, " wstrb"}, 32'(bus_if.bus_wstrb), 32'd0);
        step();
        chk({tag, " rdata"}, rdata, exp);
        chk({tag, " done stall"}, 32'(stall_mem), 32'd0);
        chk({tag, " done req"}, 32'(bus_if.bus_req), 32'd0);
        idle_inputs();
        step();
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rdata);
        rd_enM = 1'b0; wr_enM = 1'b1; funct3M = f3; ALUResultM = addr; wdataM = wd;
        bus_if.bus_rdata = 32'h5A5A_5A5A; bus_if.bus_ready = 1'b1;
        #1;
        chk({tag, " launch stall"}, 32'(stall_mem), 32'd1);
        step();
        chk({tag, " busy req"}, 32'(bus_if.bus_req), 32'd1);
        chk({tag, " we"}, 32'(bus_if.bus_we), 32'd1);
        chk({tag, " addr"}, bus_if.bus_addr, exp_addr);
        chk({tag, " wstrb"}, 32'(bus_if.bus_wstrb), 32'(exp_strb));
        chk({tag, " wdata"}, bus_if.bus_wdata, exp_wdata);
        step();
        chk({tag, " rdata kept"}, rdata, exp_rdata);
        idle_inputs();
        step();
    endtask

    task automatic do_misaligned(input string tag, input logic rd, input logic [2:0] f3,
                                 input logic [31:0] addr);
        rd_enM = rd; wr_enM = ~rd; funct3M = f3; ALUResultM = addr; wdataM = 32'h1111_2222;
        #1;
        chk({tag, " misaligned"}, 32'(misaligned), 32'd1);
        chk({tag, " stall"}, 32'(stall_mem), 32'd0);
        step();
        chk({tag, " no req"}, 32'(bus_if.bus_req), 32'd0);
        chk({tag, " still flagged"}, 32'(misaligned), 32'd1);
        idle_inputs();
        #1;
        chk({tag, " cleared"}, 32'(misaligned), 32'd0);
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        rd_enM = 1'b0; wr_enM = 1'b0; funct3M = 3'b000;
        ALUResultM = 32'h0; wdataM = 32'h0;
        bus_if.bus_rdata = 32'h0; bus_if.bus_ready = 1'b0;

        #3;
        chk("reset req", 32'(bus_if.bus_req), 32'd0);
        chk("reset we", 32'(bus_if.bus_we), 32'd0);
        chk("reset addr", bus_if.bus_addr, 32'h0);
        chk("reset wdata", bus_if.bus_wdata, 32'h0);
        chk("reset wstrb", 32'(bus_if.bus_wstrb), 32'd0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset bus_err", 32'(bus_err), 32'd0);
        chk("reset stall", 32'(stall_mem), 32'd0);
        chk("reset misaligned", 32'(misaligned), 32'd0);

        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        step();

        // Loads across lanes and sign modes.
        do_load("LW 100",  3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("LB 103",  3'b000, 32'h0000_0103, 32'h80FF_0011, 32'hFFFF_FF80);
        do_load("LHU 102", 3'b101, 32'h0000_0102, 32'h80FF_0011, 32'h0000_80FF);
        do_load("LH 102",  3'b001, 32'h0000_0102, 32'h80FF_0011, 32'hFFFF_80FF);
        do_load("LBU 102", 3'b100, 32'h0000_0102, 32'h80FF_0011, 32'h0000_00FF);
        do_load("LH 100",  3'b001, 32'h0000_0100, 32'h80FF_0011, 32'h0000_0011);
        do_load("LB 100",  3'b000, 32'h0000_0100, 32'h8000_00F0, 32'hFFFF_FFF0);
        do_load("RSV 011", 3'b011, 32'h0000_0104, 32'h80FF_0011, 32'h80FF_0011);

        // Stores; rdata must keep 0x80FF0011.
        do_store("SB 201", 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0000_0200,
                 4'b0010, 32'hABAB_ABAB, 32'h80FF_0011);
        do_store("SH 202", 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0000_0200,
                 4'b1100, 32'h1234_1234, 32'h80FF_0011);
        do_store("SW 204", 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0000_0204,
                 4'b1111, 32'hCAFE_F00D, 32'h80FF_0011);

        do_misaligned("LW 102", 1'b1, 3'b010, 32'h0000_0102);
        do_misaligned("LH 101", 1'b1, 3'b001, 32'h0000_0101);
        do_misaligned("SW 203", 1'b0, 3'b010, 32'h0000_0203);

        // One wait cycle: three stall cycles in total.
        rd_enM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_0300;
        bus_if.bus_ready = 1'b0;
        step();
        chk("wait busy1 req", 32'(bus_if.bus_req), 32'd1);
        step();
        chk("wait busy2 req", 32'(bus_if.bus_req), 32'd1);
        chk("wait busy2 stall", 32'(stall_mem), 32'd1);
        chk("wait busy2 addr", bus_if.bus_addr, 32'h0000_0300);
        bus_if.bus_rdata = 32'h0BAD_F00D; bus_if.bus_ready = 1'b1;
        step();
        chk("wait rdata", rdata, 32'h0BAD_F00D);
        chk("wait done stall", 32'(stall_mem), 32'd0);
        idle_inputs();
        step();

        // Timeout: four BUSY cycles, then error pulse and zeroed load data.
        rd_enM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_0400;
        bus_if.bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("timeout busy req", 32'(bus_if.bus_req), 32'd1);
            chk("timeout busy err", 32'(bus_err), 32'd0);
        end
        step();
        chk("timeout err pulse", 32'(bus_err), 32'd1);
        chk("timeout rdata", rdata, 32'h0);
        chk("timeout done req", 32'(bus_if.bus_req), 32'd0);
        chk("timeout done stall", 32'(stall_mem), 32'd0);
        idle_inputs();
        step();
        chk("timeout err cleared", 32'(bus_err), 32'd0);

        // Ready on the last allowed BUSY cycle beats the timeout.
        rd_enM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_0404;
        bus_if.bus_ready = 1'b0;
        repeat (3) step();
        chk("edge busy3 req", 32'(bus_if.bus_req), 32'd1);
        step();
        bus_if.bus_rdata = 32'h1357_9BDF; bus_if.bus_ready = 1'b1;
        step();
        chk("edge rdata", rdata, 32'h1357_9BDF);
        chk("edge no err", 32'(bus_err), 32'd0);
        idle_inputs();
        step();

        // Reset during the second BUSY cycle.
        rd_enM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_0500;
        bus_if.bus_ready = 1'b0;
        step();
        step();
        chk("rst busy2 req", 32'(bus_if.bus_req), 32'd1);
        rst = 1'b0; rd_enM = 1'b0;
        #1;
        chk("rst req", 32'(bus_if.bus_req), 32'd0);
        chk("rst addr", bus_if.bus_addr, 32'h0);
        chk("rst wstrb", 32'(bus_if.bus_wstrb), 32'd0);
        chk("rst we", 32'(bus_if.bus_we), 32'd0);
        chk("rst wdata", bus_if.bus_wdata, 32'h0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst stall", 32'(stall_mem), 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        @(negedge clk) rst = 1'b1;
        step();
        chk("post rst idle req", 32'(bus_if.bus_req), 32'd0);
        do_load("LW 500", 3'b010, 32'h0000_0500, 32'h600D_CAFE, 32'h600D_CAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
